div_sequencer: RTL

- Iterative shift-subtract divider plus its controlling FSM, sitting beside the execute stage as the divide engine behind the multi-cycle MDU path.
- Accepts one DIV/DIVU/REM/REMU request, sequences XLEN restoring-division iterations, applies RISC-V sign and special-case rules, and holds the result until the execute stage acknowledges it.
- Execute stage stalls while the block is busy and flushes it on pipeline flush.

---
 rtl/div_sequencer.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/div_sequencer.sv
// Iterative restoring divider with its sequencing FSM for the multi-cycle MDU path.
// Handles DIV/DIVU/REM/REMU including RISC-V divide-by-zero and signed-overflow results.
module div_sequencer #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN + 1)
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_flush,
  input  logic            i_start,
  input  logic [1:0]      i_op,
  input  logic [XLEN-1:0] i_src1,
  input  logic [XLEN-1:0] i_src2,
  input  logic            i_ack,
  output logic            o_ready,
  output logic            o_busy,
  output logic            o_valid,
  output logic [XLEN-1:0] o_dest
);

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    ITER,
    FIXUP,
    DONE
  } state_e;

  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  state_e          state_q;
  logic [1:0]      op_q;
  logic [XLEN-1:0] src1_q;
  logic [XLEN-1:0] src2_q;
  logic [XLEN-1:0] divisor_q;
  logic [XLEN-1:0] quo_q;
  logic [XLEN:0]   rem_q;
  logic [CNT_W-1:0] cnt_q;
  logic            qNeg_q;
  logic            rNeg_q;
  logic            valid_q;
  logic            busy_q;
  logic [XLEN-1:0] dest_q;

  logic            accept;
  logic            isSigned;
  logic            s1Neg;
  logic            s2Neg;
  logic [XLEN-1:0] mag1;
  logic [XLEN-1:0] mag2;
  logic            divByZero;
  logic            overflow;
  logic [XLEN:0]   remShift;
  logic [XLEN+1:0] trial;
  logic            trialOk;
  logic [XLEN:0]   remIter_d;
  logic [XLEN-1:0] quoIter_d;
  logic [XLEN-1:0] quoFix;
  logic [XLEN-1:0] remFix;

  assign o_ready = ((state_q == IDLE) || ((state_q == DONE) && i_ack)) && !i_flush && i_rst_n;
  assign accept  = i_start && o_ready;
  assign o_busy  = busy_q;
  assign o_valid = valid_q;
  assign o_dest  = dest_q;

  always_comb begin
    isSigned  = ~op_q[0];
    s1Neg     = isSigned & src1_q[XLEN-1];
    s2Neg     = isSigned & src2_q[XLEN-1];
    mag1      = s1Neg ? (~src1_q + 1'b1) : src1_q;
    mag2      = s2Neg ? (~src2_q + 1'b1) : src2_q;
    divByZero = (src2_q == '0);
    overflow  = isSigned && (src1_q == MIN_VAL) && (src2_q == '1);

    // The bit shifted out of rem_q acts as a borrow guard for the trial subtraction.
    remShift  = {rem_q[XLEN-1:0], quo_q[XLEN-1]};
    trial     = {1'b0, remShift} - {2'b00, divisor_q};
    trialOk   = rem_q[XLEN] | ~trial[XLEN+1];
    remIter_d = trialOk ? trial[XLEN:0] : remShift;
    quoIter_d = {quo_q[XLEN-2:0], trialOk};

    quoFix    = qNeg_q ? (~quo_q + 1'b1) : quo_q;
    remFix    = rNeg_q ? (~rem_q[XLEN-1:0] + 1'b1) : rem_q[XLEN-1:0];
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      op_q      <= '0;
      src1_q    <= '0;
      src2_q    <= '0;
      divisor_q <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      qNeg_q    <= 1'b0;
      rNeg_q    <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      dest_q    <= '0;
    end else if (i_flush) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      if (accept) begin
        op_q   <= i_op;
        src1_q <= i_src1;
        src2_q <= i_src2;
      end
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q <= PREP;
            busy_q  <= 1'b1;
          end
        end
        PREP: begin
          qNeg_q    <= s1Neg ^ s2Neg;
          rNeg_q    <= s1Neg;
          divisor_q <= mag2;
          if (divByZero) begin
            dest_q  <= op_q[1] ? src1_q : '1;
            state_q <= DONE;
            busy_q  <= 1'b0;
            valid_q <= 1'b1;
          end else if (overflow) begin
            dest_q  <= op_q[1] ? '0 : MIN_VAL;
            state_q <= DONE;
            busy_q  <= 1'b0;
            valid_q <= 1'b1;
          end else begin
            cnt_q   <= CNT_W'(XLEN);
            rem_q   <= '0;
            quo_q   <= mag1;
            state_q <= ITER;
          end
        end
        ITER: begin
          rem_q <= remIter_d;
          quo_q <= quoIter_d;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            state_q <= FIXUP;
          end
        end
        FIXUP: begin
          dest_q  <= op_q[1] ? remFix : quoFix;
          state_q <= DONE;
          busy_q  <= 1'b0;
          valid_q <= 1'b1;
        end
        DONE: begin
          if (i_ack) begin
            valid_q <= 1'b0;
            if (accept) begin
              state_q <= PREP;
              busy_q  <= 1'b1;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
